// File: rtl/morse_pkg.sv
// Shared constants, FSM encoding and letter mapping for the Morse receive controller.
// No logic of its own; timing and backpressure live in the modules that import it.
package morse_pkg;

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN    = 8'h3F;
  localparam int         UNIT_CYCLES      = 8;
  localparam int         WORD_GAP_DEFAULT = 7 * UNIT_CYCLES;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_IN_WORD  = 2'd2
  } state_t;

  // A decoder that could not match a pattern reports 0x00; show it as '?'.
  function automatic logic [7:0] char_of(input logic [7:0] letter);
    return (letter == 8'h00) ? ASCII_UNKNOWN : letter;
  endfunction

endpackage

// File: rtl/morse_rx_controller_if.sv
// Decoder-side and consumer-side signals of the Morse receive controller.
// slave = controller, master = whoever drives the decoder/consumer side.
interface morse_rx_controller_if #(
  parameter int DEPTH = 8
);
  logic                   enable;
  logic                   clear;
  logic                   signal;
  logic [7:0]             letter;
  logic                   done;
  logic                   decoder_rst;
  logic [7:0]             out_char;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overflow;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output enable, clear, signal, letter, done, out_ready,
    input  decoder_rst, out_char, out_valid, overflow, count
  );

  modport slave (
    input  enable, clear, signal, letter, done, out_ready,
    output decoder_rst, out_char, out_valid, overflow, count
  );
endinterface

// File: rtl/morse_char_fifo.sv
// Character FIFO: push in cycle N is visible at the head in N+1; full+pop+push keeps count.
// Pushes into a full FIFO without a same-cycle pop are refused; clear drops the cycle's push/pop.
module morse_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [7:0]             push_dat,
  input  logic                   pop,
  output logic [7:0]             head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty && !clear;
  // A slot freed by this cycle's pop may be reused by this cycle's push.
  assign push_ok = push && !clear && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = empty ? 8'h00 : mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/morse_rx_controller.sv
// Turns decoder letters and long low gaps into a character stream; push visible one cycle later.
// Consumer backpressure via out_ready; when the FIFO is full new characters drop and set overflow.
module morse_rx_controller
  import morse_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WORD_GAP = WORD_GAP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  morse_rx_controller_if.slave   bus
);
  localparam int GW = $clog2(WORD_GAP + 1);

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          gap_hit;
  logic          letter_push;
  logic          space_push;
  logic          push;
  logic [7:0]    push_dat;
  logic          pop;
  logic          full;
  logic          empty;

  assign gap_hit = (gap_cnt == GW'(WORD_GAP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_DISABLED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    letter_push = 1'b0;
    space_push  = 1'b0;
    if (!bus.enable) begin
      state_nxt = ST_DISABLED;
    end else if (bus.clear) begin
      state_nxt = (state == ST_DISABLED) ? ST_DISABLED : ST_IDLE;
    end else begin
      case (state)
        ST_DISABLED: state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (bus.done) begin
            letter_push = 1'b1;
            state_nxt   = ST_IN_WORD;
          end
        end
        ST_IN_WORD: begin
          // A letter arriving on the gap boundary wins; the word continues.
          if (bus.done) begin
            letter_push = 1'b1;
          end else if (gap_hit) begin
            space_push = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
        default: state_nxt = ST_DISABLED;
      endcase
    end
  end

  assign push     = letter_push || space_push;
  assign push_dat = letter_push ? char_of(bus.letter) : ASCII_SPACE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (!bus.enable || state == ST_DISABLED || bus.clear || bus.signal || letter_push) begin
      gap_cnt <= '0;
    end else if (!gap_hit) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      bus.overflow <= 1'b0;
    else if (bus.clear)             bus.overflow <= 1'b0;
    else if (push && full && !pop)  bus.overflow <= 1'b1;
  end

  morse_char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .clear    (bus.clear),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (bus.out_char),
    .full     (full),
    .empty    (empty),
    .count    (bus.count)
  );

  assign bus.out_valid   = !empty;
  assign bus.decoder_rst = (state == ST_DISABLED);

endmodule
